rom_arbiter: RTL and testbench
==============================

# rom_arbiter

Round-robin arbiter and sequencer that shares one single-port ROM (negedge-read, `sink_cen`/`sink_ren` gated, registered `src_data`) between up to four requesters, e.g. instruction fetch, constant loader, debug port. It sits between the requesters and the ROM instance. It issues at most one ROM read per cycle and returns the data to the granted requester with a one-cycle valid pulse.

## Interface
- `NUM_REQ`, 2: number of requesters, 2..4.
- `ADDRESS_WIDTH`, 16: ROM address width; matches the ROM instance.
- `DATA_WIDTH`, 16: ROM data width; matches the ROM instance.
- `clk` input 1: system clock; all state updates on posedge.
- `rst_n` input 1: asynchronous, active-low reset.
- `sink_req` input NUM_REQ: per-requester read request (level).
- `sink_address` input NUM_REQ*ADDRESS_WIDTH: packed request addresses; requester i at slice i.
- `src_gnt` output NUM_REQ: one-hot grant, combinational, same cycle as request.
- `src_rvalid` output NUM_REQ: one-hot registered read-data valid pulse.
- `src_rdata` output DATA_WIDTH: read data shared by all requesters; qualified by `src_rvalid`.
- `src_rom_address` output ADDRESS_WIDTH: registered ROM address.
- `src_rom_cen` output 1: registered ROM chip enable.
- `src_rom_ren` output 1: registered ROM read enable.
- `sink_rom_data` input DATA_WIDTH: ROM `src_data`.

## Operation
- Requester i holds `sink_req[i]` and a stable address until it sees `src_gnt[i]` high at a posedge. The request is consumed at that edge. Holding req high afterwards is a new request.
- Arbitration uses a round-robin pointer `last_gnt`. The search starts at `last_gnt+1` mod NUM_REQ. The first active request wins. `last_gnt` updates only on a grant.
- On a grant at posedge T, the following are registered: `src_rom_address`=address, `src_rom_cen`=`src_rom_ren`=1, `inflight_id`=i.
- The ROM samples at the negedge inside cycle T+1. Data is stable at posedge T+2.
- `src_rvalid[inflight_id]` is asserted for the cycle after issue (registered at T+1, sampled by requester at T+2). `src_rdata`=`sink_rom_data` pass-through.
- Back-to-back grants are allowed: throughput is 1 read/cycle with a fully pipelined issue/return.
- FSM is IDLE / ACTIVE.
  - IDLE: cen=ren=0. On any request: grant, go to ACTIVE.
  - ACTIVE: a read is issued this cycle. On a request: grant, stay. On no request: go to IDLE, deassert cen/ren.
- No request: `src_gnt`=0, cen/ren=0, `src_rom_address` holds its last value.
- Requests with `sink_req` low are ignored regardless of address. Address bits beyond ROM depth do not exist (widths match).

## Timing
- Reset values: `src_gnt`=0 (no requests are granted while `rst_n`=0), `src_rvalid`=0, `src_rom_cen`=`src_rom_ren`=0, `src_rom_address`=0, `last_gnt`=NUM_REQ-1 (requester 0 wins first), state IDLE.
- Grant latency: 0 cycles (combinational). Data latency: request-accept edge T to valid data edge T+2.
- Reset asserted mid-operation: the in-flight read is discarded, and no `src_rvalid` pulse follows reset release. `src_rdata` is undefined until the first `src_rvalid`. The ROM output is not reset.
- Simultaneous requests: exactly one grant per cycle. Under continuous contention, each of k active requesters is served once every k cycles.

## Configuration
- `ROM_ARB_PRIORITY_EN` defined: requester 0 has fixed highest priority. The others are round-robin among themselves when requester 0 is idle. Requester 0 can starve the others; this is intended for the instruction fetch path.
- Undefined (default): pure round-robin across all NUM_REQ requesters, as described above.

## Structure
- Shared package `rom_arb_pkg`:
  - typedef `arb_state_t` {IDLE, ACTIVE}.
  - constant `MAX_REQ`=4.
  - function `rr_pick(req, last)` returning the one-hot winner.
- One sub-module, `rr_picker`: combinational round-robin selection (req vector, pointer → one-hot grant, index). The FSM and the pipeline registers stay in `rom_arbiter`.

## Test plan
- Reset release, no requests → cen=ren=0, `src_gnt`=0, `src_rvalid`=0 for 10 cycles.
- Req0 alone, addr 0x0010, ROM preloaded mem[0x10]=0xBEEF → gnt0 same cycle, `src_rom_address`=0x0010 next edge, `src_rvalid[0]`=1 and `src_rdata`=0xBEEF one cycle later, single pulse.
- Req0 and req1 held high continuously, addresses 0x0001/0x0002 → grants alternate 0,1,0,1. rvalid alternates one cycle behind, with data mem[1]/mem[2]. One read every cycle.
- Reset asserted the cycle after a grant to req1 → no `src_rvalid[1]` after release. First post-reset grant goes to req0.
- NUM_REQ=4, all requesting, `ROM_ARB_PRIORITY_EN` defined → req0 granted every cycle. Drop req0 → grants 1,2,3,1. Undefined → grants 0,1,2,3,0.
- Req2 alone for 3 consecutive cycles with addresses 5,6,7 → three consecutive rvalid[2] pulses with data mem[5], mem[6], mem[7]. FSM stays ACTIVE, then returns to IDLE.

Source files
------------

// File: rtl/rom_arb_pkg.sv
// Shared types and helpers for the ROM arbiter: FSM states, requester limit,
// round-robin pick and one-hot to index conversion.
package rom_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } arb_state_t;

  localparam int MAX_REQ = 4;

  // Search starts one past the last winner and wraps; unused requester slots
  // are zero, so wrapping over MAX_REQ equals wrapping over NUM_REQ.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                 input logic [1:0]         last);
    logic [MAX_REQ-1:0] gnt;
    logic [1:0]         idx;
    gnt = '0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      idx = last + 2'(k);
      if (req[idx] && (gnt == '0)) begin
        gnt[idx] = 1'b1;
      end else begin
        gnt = gnt;
      end
    end
    return gnt;
  endfunction

  function automatic logic [1:0] onehot_idx(input logic [MAX_REQ-1:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) begin
        idx = idx | 2'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rom_arbiter_rr_picker.sv
// Combinational winner selection for rom_arbiter.
// ROM_ARB_PRIORITY_EN: requester 0 always wins; the rest rotate when it is idle.
module rr_picker
  import rom_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [1:0]         last_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [1:0]         idx_o
);

  logic [MAX_REQ-1:0] req_ext_s;
  logic [MAX_REQ-1:0] gnt_ext_s;

  // Widen the request vector and choose the winner.
  always_comb begin
    req_ext_s                = '0;
    req_ext_s[NUM_REQ-1:0]   = req_i;
    gnt_ext_s                = '0;
`ifdef ROM_ARB_PRIORITY_EN
    if (req_ext_s[0]) begin
      gnt_ext_s[0] = 1'b1;
    end else begin
      gnt_ext_s = rr_pick(req_ext_s, last_i);
    end
`else
    gnt_ext_s = rr_pick(req_ext_s, last_i);
`endif
  end

  assign gnt_o = gnt_ext_s[NUM_REQ-1:0];
  assign idx_o = onehot_idx(gnt_ext_s);

endmodule

// File: rtl/rom_arbiter.sv
// Round-robin arbiter sharing one negedge-read ROM among 2..4 requesters.
// Optional ROM_ARB_PRIORITY_EN gives requester 0 fixed top priority.
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int NUM_REQ       = 2,
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_REQ-1:0]                 sink_req,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0]   sink_address,
  output logic [NUM_REQ-1:0]                 src_gnt,
  output logic [NUM_REQ-1:0]                 src_rvalid,
  output logic [DATA_WIDTH-1:0]              src_rdata,
  output logic [ADDRESS_WIDTH-1:0]           src_rom_address,
  output logic                               src_rom_cen,
  output logic                               src_rom_ren,
  input  logic [DATA_WIDTH-1:0]              sink_rom_data
);

  localparam logic [1:0] LAST_RST = 2'(NUM_REQ - 1);

  logic [NUM_REQ-1:0]       pick_gnt_s;
  logic [1:0]               pick_idx_s;
  logic                     any_gnt_s;
  logic [ADDRESS_WIDTH-1:0] sel_addr_s;

  arb_state_t               state_d, state_q;
  logic [1:0]               last_d, last_q;
  logic [1:0]               inflight_d, inflight_q;
  logic [ADDRESS_WIDTH-1:0] addr_d, addr_q;
  logic                     cen_d, cen_q;
  logic                     ren_d, ren_q;
  logic [NUM_REQ-1:0]       rvalid_d, rvalid_q;

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req_i  (sink_req),
    .last_i (last_q),
    .gnt_o  (pick_gnt_s),
    .idx_o  (pick_idx_s)
  );

  // Nothing may be granted while reset is held.
  assign src_gnt   = pick_gnt_s & {NUM_REQ{rst_n}};
  assign any_gnt_s = |src_gnt;

  // Address of the winning requester.
  always_comb begin
    sel_addr_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_gnt_s[i]) begin
        sel_addr_s = sink_address[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      end else begin
        sel_addr_s = sel_addr_s;
      end
    end
  end

  // Sequencer: a grant issues a read next cycle; no grant drops cen/ren.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    inflight_d = inflight_q;
    addr_d     = addr_q;
    cen_d      = 1'b0;
    ren_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_gnt_s) begin
          state_d    = ACTIVE;
          last_d     = pick_idx_s;
          inflight_d = pick_idx_s;
          addr_d     = sel_addr_s;
          cen_d      = 1'b1;
          ren_d      = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      ACTIVE: begin
        if (any_gnt_s) begin
          state_d    = ACTIVE;
          last_d     = pick_idx_s;
          inflight_d = pick_idx_s;
          addr_d     = sel_addr_s;
          cen_d      = 1'b1;
          ren_d      = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The read issued last cycle returns to its owner now.
  always_comb begin
    rvalid_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rvalid_d[i] = cen_q && (inflight_q == 2'(i));
    end
  end

  // State and pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_q     <= LAST_RST;
      inflight_q <= 2'd0;
      addr_q     <= '0;
      cen_q      <= 1'b0;
      ren_q      <= 1'b0;
      rvalid_q   <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      inflight_q <= inflight_d;
      addr_q     <= addr_d;
      cen_q      <= cen_d;
      ren_q      <= ren_d;
      rvalid_q   <= rvalid_d;
    end
  end

  assign src_rvalid      = rvalid_q;
  assign src_rdata       = sink_rom_data;
  assign src_rom_address = addr_q;
  assign src_rom_cen     = cen_q;
  assign src_rom_ren     = ren_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Self-checking bench for rom_arbiter with four requesters and a behavioural ROM.
module tb_rom_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 16;
  localparam int DW   = 16;

  logic               clk;
  logic               rst_n;
  logic [NREQ-1:0]    sink_req;
  logic [NREQ*AW-1:0] sink_address;
  logic [NREQ-1:0]    src_gnt;
  logic [NREQ-1:0]    src_rvalid;
  logic [DW-1:0]      src_rdata;
  logic [AW-1:0]      src_rom_address;
  logic               src_rom_cen;
  logic               src_rom_ren;
  logic [DW-1:0]      rom_q;

  int checks = 0;
  int fails  = 0;

  rom_arbiter #(
    .NUM_REQ       (NREQ),
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .sink_req        (sink_req),
    .sink_address    (sink_address),
    .src_gnt         (src_gnt),
    .src_rvalid      (src_rvalid),
    .src_rdata       (src_rdata),
    .src_rom_address (src_rom_address),
    .src_rom_cen     (src_rom_cen),
    .src_rom_ren     (src_rom_ren),
    .sink_rom_data   (rom_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rom_val(input logic [AW-1:0] a);
    if (a == 16'h0010) return 16'hBEEF;
    return (a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  // Single-port ROM: samples on negedge when enabled, output not reset.
  always @(negedge clk) begin
    if (src_rom_cen && src_rom_ren) rom_q <= rom_val(src_rom_address);
  end

  // Reference model state
  typedef struct {
    int            cyc;
    int            id;
    logic [DW-1:0] data;
  } ret_t;
  ret_t          rq[$];
  int            m_last;
  logic [AW-1:0] m_addr;
  int            cyc_n;

  function automatic int model_pick(input logic [NREQ-1:0] req);
`ifdef ROM_ARB_PRIORITY_EN
    if (req[0]) return 0;
`endif
    for (int k = 1; k <= NREQ; k++) begin
      int c;
      c = (m_last + k) % NREQ;
`ifdef ROM_ARB_PRIORITY_EN
      if (c == 0) continue;
`endif
      if (req[c]) return c;
    end
    return -1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: apply request, check grant, then check the registered side.
  task automatic cycle(input logic [NREQ-1:0] req, input logic [NREQ*AW-1:0] addrs,
                       output logic [NREQ-1:0] got);
    int              w;
    logic [NREQ-1:0] exp_gnt;
    logic [NREQ-1:0] exp_rv;
    logic [DW-1:0]   exp_data;
    sink_req     = req;
    sink_address = addrs;
    #3;
    w       = model_pick(req);
    exp_gnt = (w < 0) ? 4'b0000 : (4'b0001 << w);
    check("gnt", 64'(src_gnt), 64'(exp_gnt));
    got = src_gnt;
    @(posedge clk);
    #1;
    cyc_n++;
    exp_rv   = '0;
    exp_data = '0;
    if (rq.size() > 0 && rq[0].cyc == cyc_n - 1) begin
      exp_rv[rq[0].id] = 1'b1;
      exp_data         = rq[0].data;
      void'(rq.pop_front());
    end
    check("rvalid", 64'(src_rvalid), 64'(exp_rv));
    if (exp_rv != '0) check("rdata", 64'(src_rdata), 64'(exp_data));
    if (w >= 0) begin
      m_addr = addrs[w*AW +: AW];
      m_last = w;
      rq.push_back('{cyc_n, w, rom_val(m_addr)});
    end
    check("cen", 64'(src_rom_cen), 64'(w >= 0));
    check("ren", 64'(src_rom_ren), 64'(w >= 0));
    check("rom_addr", 64'(src_rom_address), 64'(m_addr));
  endtask

  typedef struct {
    logic [NREQ-1:0]    req;
    logic [NREQ*AW-1:0] addrs;
    logic [NREQ-1:0]    exp_gnt;
  } vec_t;
  vec_t tbl[20];

  logic [NREQ-1:0]    g;
  logic [NREQ-1:0]    pend;
  logic [AW-1:0]      ra[NREQ];
  logic [NREQ*AW-1:0] a12;
  logic [NREQ*AW-1:0] a1234;

  initial begin
    a12   = {16'h0000, 16'h0000, 16'h0002, 16'h0001};
    a1234 = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
    tbl[0]  = '{4'b0001, {48'h0, 16'h0010}, 4'b0001};
    tbl[1]  = '{4'b0000, 64'h0, 4'b0000};
    tbl[2]  = '{4'b0000, 64'h0, 4'b0000};
    tbl[3]  = '{4'b0011, a12, 4'b0010};
    tbl[4]  = '{4'b0011, a12, 4'b0001};
    tbl[5]  = '{4'b0011, a12, 4'b0010};
    tbl[6]  = '{4'b0011, a12, 4'b0001};
`ifdef ROM_ARB_PRIORITY_EN
    tbl[7]  = '{4'b1111, a1234, 4'b0001};
    tbl[8]  = '{4'b1111, a1234, 4'b0001};
    tbl[9]  = '{4'b1111, a1234, 4'b0001};
    tbl[10] = '{4'b1111, a1234, 4'b0001};
`else
    tbl[7]  = '{4'b1111, a1234, 4'b0010};
    tbl[8]  = '{4'b1111, a1234, 4'b0100};
    tbl[9]  = '{4'b1111, a1234, 4'b1000};
    tbl[10] = '{4'b1111, a1234, 4'b0001};
`endif
    tbl[11] = '{4'b1110, a1234, 4'b0010};
    tbl[12] = '{4'b1110, a1234, 4'b0100};
    tbl[13] = '{4'b1110, a1234, 4'b1000};
    tbl[14] = '{4'b1110, a1234, 4'b0010};
    tbl[15] = '{4'b0100, {16'h0, 16'h0005, 32'h0}, 4'b0100};
    tbl[16] = '{4'b0100, {16'h0, 16'h0006, 32'h0}, 4'b0100};
    tbl[17] = '{4'b0100, {16'h0, 16'h0007, 32'h0}, 4'b0100};
    tbl[18] = '{4'b0000, 64'h0, 4'b0000};
    tbl[19] = '{4'b0000, 64'h0, 4'b0000};

    m_last = NREQ - 1;
    m_addr = '0;
    cyc_n  = 0;

    // Reset: requests present but nothing granted, outputs cleared.
    rst_n        = 1'b0;
    sink_req     = 4'b1111;
    sink_address = a1234;
    #2;
    check("rst_gnt", 64'(src_gnt), 64'h0);
    check("rst_rvalid", 64'(src_rvalid), 64'h0);
    check("rst_cen", 64'(src_rom_cen), 64'h0);
    check("rst_addr", 64'(src_rom_address), 64'h0);
    sink_req = 4'b0000;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) cycle(4'b0000, 64'h0, g);

    for (int i = 0; i < 20; i++) begin
      cycle(tbl[i].req, tbl[i].addrs, g);
      check($sformatf("tbl_gnt[%0d]", i), 64'(g), 64'(tbl[i].exp_gnt));
    end

    // Reset right after a grant to requester 1 discards that read.
    cycle(4'b0010, a12, g);
    check("pre_rst_gnt", 64'(g), 64'h2);
    rst_n = 1'b0;
    #2;
    check("mid_rst_rvalid", 64'(src_rvalid), 64'h0);
    check("mid_rst_cen", 64'(src_rom_cen), 64'h0);
    check("mid_rst_gnt", 64'(src_gnt), 64'h0);
    rq.delete();
    m_last = NREQ - 1;
    m_addr = '0;
    @(posedge clk);
    #1;
    check("mid_rst_rvalid2", 64'(src_rvalid), 64'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cycle(4'b0000, 64'h0, g);
    cycle(4'b0011, a12, g);
    check("post_rst_gnt", 64'(g), 64'h1);

    // Randomized traffic; each requester holds its address until granted.
    pend = '0;
    for (int i = 0; i < NREQ; i++) ra[i] = '0;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i]) begin
          pend[i] = ($urandom_range(0, 2) != 0);
          ra[i]   = AW'($urandom);
        end
      end
      cycle(pend, {ra[3], ra[2], ra[1], ra[0]}, g);
      pend = pend & ~g;
    end
    cycle(4'b0000, 64'h0, g);
    cycle(4'b0000, 64'h0, g);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
